// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: decodes custom-0 ADD/XOR/MUL/NOP, executes them
// (MUL iteratively, one shift-add step per cycle) and returns results in order via a FIFO.
module cvxif_copro_responder #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IdWidth  = 2,
    parameter int unsigned ResDepth = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [XLEN-1:0]    result_data_o,
    output logic [4:0]         result_rd_o,
    output logic               result_we_o,
    output logic               busy_o
);

    localparam int unsigned PtrW    = (ResDepth > 1) ? $clog2(ResDepth) : 1;
    localparam int unsigned CntW    = $clog2(ResDepth + 1);
    localparam int unsigned MulCntW = $clog2(XLEN + 1);

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b001;
    localparam logic [2:0] F3_MUL = 3'b010;
    localparam logic [2:0] F3_NOP = 3'b011;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] dec_rd;
    logic       dec_accept;
    logic       dec_wb;
    logic       handshake;
    logic       mul_start;
    logic       mul_done;
    logic       alu_push;
    logic       push;
    logic       pop;
    logic       unused_fields;

    logic [XLEN-1:0]    alu_result;
    logic [IdWidth-1:0] push_id;
    logic [XLEN-1:0]    push_data;
    logic [4:0]         push_rd;
    logic               push_we;

    logic [XLEN-1:0]    mul_acc, mul_acc_next, mul_mcand, mul_mplier;
    logic [MulCntW-1:0] mul_cnt;
    logic [IdWidth-1:0] mul_id;
    logic [4:0]         mul_rd;

    logic [IdWidth-1:0] fifo_id   [ResDepth];
    logic [XLEN-1:0]    fifo_data [ResDepth];
    logic [4:0]         fifo_rd   [ResDepth];
    logic               fifo_we   [ResDepth];
    logic [PtrW-1:0]    wptr, rptr;
    logic [CntW-1:0]    count;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(ResDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign opcode        = issue_instr_i[6:0];
    assign funct7        = issue_instr_i[31:25];
    assign funct3        = issue_instr_i[14:12];
    assign dec_rd        = issue_instr_i[11:7];
    assign unused_fields = ^issue_instr_i[24:15];

    always_comb begin
        dec_accept = (opcode == 7'b0001011) && (funct7 == 7'd0) && !funct3[2];
        dec_wb     = dec_accept && (funct3 != F3_NOP) && (dec_rd != 5'd0);
    end

    assign issue_ready_o     = !rst_i && !flush_i && (state_q == IDLE) && (count < CntW'(ResDepth));
    assign handshake         = issue_valid_i && issue_ready_o;
    assign issue_accept_o    = handshake && dec_accept;
    assign issue_writeback_o = handshake && dec_wb;
    assign mul_start         = issue_accept_o && (funct3 == F3_MUL);
    assign alu_push          = issue_accept_o && (funct3 != F3_MUL);
    assign busy_o            = (state_q == MUL_BUSY);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        mul_done = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (mul_start) state_d = MUL_BUSY;
                MUL_BUSY: if (mul_cnt == MulCntW'(1)) begin
                    state_d  = IDLE;
                    mul_done = 1'b1;
                end
                default:  state_d = IDLE;
            endcase
        end
    end

    // Multiplicand shifts left, multiplier right; after XLEN steps acc holds the low half.
    assign mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_id     <= '0;
            mul_rd     <= '0;
        end else if (mul_start) begin
            mul_cnt    <= MulCntW'(XLEN);
            mul_acc    <= '0;
            mul_mcand  <= issue_rs1_i;
            mul_mplier <= issue_rs2_i;
            mul_id     <= issue_id_i;
            mul_rd     <= dec_rd;
        end else if (state_q == MUL_BUSY) begin
            mul_cnt    <= mul_cnt - MulCntW'(1);
            mul_acc    <= mul_acc_next;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
        end
    end

    always_comb begin
        case (funct3)
            F3_ADD:  alu_result = issue_rs1_i + issue_rs2_i;
            F3_XOR:  alu_result = issue_rs1_i ^ issue_rs2_i;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        push      = alu_push || mul_done;
        push_id   = issue_id_i;
        push_data = alu_result;
        push_rd   = dec_rd;
        push_we   = dec_wb;
        if (mul_done) begin
            push_id   = mul_id;
            push_data = mul_acc_next;
            push_rd   = mul_rd;
            push_we   = (mul_rd != 5'd0);
        end
    end

    assign pop = result_valid_o && result_ready_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_id[wptr]   <= push_id;
            fifo_data[wptr] <= push_data;
            fifo_rd[wptr]   <= push_rd;
            fifo_we[wptr]   <= push_we;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        result_valid_o = (count != '0);
        result_id_o    = '0;
        result_data_o  = '0;
        result_rd_o    = '0;
        result_we_o    = 1'b0;
        if (result_valid_o) begin
            result_id_o   = fifo_id[rptr];
            result_data_o = fifo_data[rptr];
            result_rd_o   = fifo_rd[rptr];
            result_we_o   = fifo_we[rptr];
        end
    end

endmodule
